// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - phase, op-code and flag types shared by the word-serial ALU
package alu_pkg;

  typedef enum logic [2:0] {
    GET_WORD_IN   = 3'b001,
    MUX_WORD_OUT  = 3'b010,
    LAST_WORD_OUT = 3'b100
  } alu_op;

  typedef enum logic [2:0] {
    FN_ADD    = 3'd0,
    FN_SUB    = 3'd1,
    FN_AND    = 3'd2,
    FN_OR     = 3'd3,
    FN_XOR    = 3'd4,
    FN_PASS_A = 3'd5
  } alu_fn_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/word_serial_alu_slice.sv
// rtl/word_serial_alu_slice.sv - combinational single-word ALU step with carry in/out
module word_serial_alu_slice
  import alu_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  input  alu_fn_e           fn,
  output logic [WORD_W-1:0] r,
  output logic              cout,
  output logic              ovf
);

  logic [WORD_W-1:0] b_eff;
  logic [WORD_W:0]   sum;

  always_comb begin
    b_eff = (fn == FN_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WORD_W{1'b0}}, cin};
    r     = '0;
    cout  = 1'b0;
    ovf   = 1'b0;
    case (fn)
      FN_ADD, FN_SUB: begin
        r    = sum[WORD_W-1:0];
        cout = sum[WORD_W];
        ovf  = (a[WORD_W-1] == b_eff[WORD_W-1]) && (r[WORD_W-1] != a[WORD_W-1]);
      end
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_XOR:  r = a ^ b;
      // reserved codes 6-7 fall through to PASS_A
      default: r = a;
    endcase
  end

endmodule

// File: rtl/word_serial_alu.sv
// rtl/word_serial_alu.sv - multi-word ALU: word-serial operands in, buffered result words out
module word_serial_alu
  import alu_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int N_WORDS = 4,
  parameter int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic [2:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_ovf,
  output logic [2:0]        phase
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'((N_WORDS > 1) ? N_WORDS - 2 : 0);

  alu_op             state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  alu_fn_e           fn_q;
  logic              carry_q, nz_q, ovf_q;
  logic [WORD_W-1:0] res_buf [N_WORDS];

  logic              in_hs, out_hs, first_word;
  alu_fn_e           fn_cur;
  logic              cin;
  logic [WORD_W-1:0] r;
  logic              cout, ovf;
  alu_flags_t        flags, flags_out;

  assign in_hs      = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign first_word = (idx_q == '0);
  // word 0 uses the live op code; later words use the copy latched on word 0
  assign fn_cur     = first_word ? alu_fn_e'(in_op) : fn_q;
  assign cin        = first_word ? (alu_fn_e'(in_op) == FN_SUB) : carry_q;

  word_serial_alu_slice #(.WORD_W(WORD_W)) u_slice (
    .a    (in_a),
    .b    (in_b),
    .cin  (cin),
    .fn   (fn_cur),
    .r    (r),
    .cout (cout),
    .ovf  (ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= GET_WORD_IN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state_q)
      GET_WORD_IN: begin
        in_ready = 1'b1;
        if (in_valid && idx_q == LAST_IDX)
          state_d = (N_WORDS > 1) ? MUX_WORD_OUT : LAST_WORD_OUT;
      end
      MUX_WORD_OUT: begin
        out_valid = 1'b1;
        out_data  = res_buf[idx_q];
        if (out_ready && idx_q == PENULT_IDX) state_d = LAST_WORD_OUT;
      end
      LAST_WORD_OUT: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = res_buf[LAST_IDX];
        if (out_ready) state_d = GET_WORD_IN;
      end
      default: state_d = GET_WORD_IN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      fn_q    <= FN_ADD;
      carry_q <= 1'b0;
      nz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (in_hs) begin
      if (first_word) fn_q <= alu_fn_e'(in_op);
      carry_q <= cout;
      nz_q    <= nz_q | (r != '0);
      if (idx_q == LAST_IDX) begin
        idx_q <= '0;
        ovf_q <= ovf;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end else if (out_hs) begin
      if (out_last) begin
        idx_q   <= '0;
        carry_q <= 1'b0;
        nz_q    <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) res_buf[idx_q] <= r;
  end

  assign flags     = '{carry: carry_q, zero: ~nz_q, ovf: ovf_q};
  assign flags_out = out_last ? flags : '0;
  assign out_carry = flags_out.carry;
  assign out_zero  = flags_out.zero;
  assign out_ovf   = flags_out.ovf;
  assign phase     = state_q;

endmodule

// File: doc/word_serial_alu.md
Name: word_serial_alu

Overview:
- Parametrised multi-word ALU engine: accepts two N_WORDS x WORD_W operands as a word-serial stream, least-significant word first. Computes the selected operation with a carry chain across words and buffers the result words.
- Streams the result back out word-serially, asserting a last-word flag and result status flags on the final word.
- Sits between the operand word source and the result sink. The sequencer uses the shared GET_WORD_IN / MUX_WORD_OUT / LAST_WORD_OUT one-hot phase encoding.

Parameters:
- WORD_W, 16, bits per word (>=2).
- N_WORDS, 4, words per operand/result (>=1).
- IDX_W, $clog2(N_WORDS) with minimum 1, derived, word index width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  engine accepts operand word pair.
- in_a  in  WORD_W  operand A word.
- in_b  in  WORD_W  operand B word.
- in_op  in  3  operation code; sampled on word 0 only.
- out_valid  out  1  result word valid.
- out_ready  in  1  sink accepts result word.
- out_data  out  WORD_W  result word.
- out_last  out  1  final result word.
- out_carry  out  1  carry out (ADD) / no-borrow (SUB); valid with out_last.
- out_zero  out  1  entire result is zero; valid with out_last.
- out_ovf  out  1  signed overflow of full-width result; valid with out_last.
- phase  out  3  current one-hot phase (alu_op encoding).

Behaviour:
- Reset (async assert, sync deassert by design):
  - phase=GET_WORD_IN; word index=0; carry and zero accumulators cleared.
  - All outputs 0 except in_ready=1.
  - The result buffer is not reset.
- GET_WORD_IN:
  - in_ready=1, out_valid=0.
  - Handshake = in_valid & in_ready.
  - On handshake at index 0: latch in_op. The latched op applies to all words of the transaction; in_op on later words is ignored.
  - On each handshake: compute the word, write buf[idx], update the carry register and the zero accumulator, then idx++.
  - On the handshake of word N_WORDS-1: idx<=0. Next phase is MUX_WORD_OUT if N_WORDS>1, else LAST_WORD_OUT.
- Ops:
  - 0 ADD: r=a+b+c. c starts at 0.
  - 1 SUB: r=a+~b+c. c starts at 1; carry=1 means no borrow.
  - 2 AND, 3 OR, 4 XOR, 5 PASS_A.
  - 6-7 are reserved and behave as PASS_A.
  - Logic ops force carry=0 and ovf=0.
- Width rules:
  - Per-word sum is WORD_W+1 bits; the MSB is the next carry.
  - ovf is computed on word N_WORDS-1 only: (a_msb == b_eff_msb) & (r_msb != a_msb), with b_eff = ~b for SUB.
- MUX_WORD_OUT:
  - out_valid=1; out_data=buf[idx]; out_last=0; in_ready=0.
  - On out_valid & out_ready: idx++. If idx was N_WORDS-2, go to LAST_WORD_OUT.
  - Without a handshake, out_data is held stable.
- LAST_WORD_OUT:
  - out_valid=1; out_last=1; out_data=buf[N_WORDS-1]; out_carry/out_zero/out_ovf are valid.
  - On handshake: go to GET_WORD_IN, idx=0, clear accumulators. in_ready rises the next cycle (no same-cycle turnaround).
  - Flags read 0 whenever out_last=0.
- Latency: the first result word is valid the cycle after the final input handshake. Throughput is 1 word/cycle in each direction.
- Reset mid-transaction: all progress is discarded immediately; no partial output.
- out_ready asserted outside the output phases is ignored. in_valid asserted outside GET_WORD_IN is ignored.

Decomposition:
- alu_pkg holds:
  - alu_op phase enum (GET_WORD_IN=3'b001, MUX_WORD_OUT=3'b010, LAST_WORD_OUT=3'b100), 3-bit.
  - alu_fn_e op-code enum (ADD..PASS_A).
  - alu_flags_t struct {carry, zero, ovf}.
- One sub-module, word_serial_alu_slice: combinational single-word op.
  - Inputs: a, b, cin, fn.
  - Outputs: r, cout, ovf.
  - Instantiated once; the top holds the FSM, index counter, buffer and flag registers.

Test Plan:
- ADD, W=16/N=4: A=0x0000_0000_0000_FFFF, B=0x...0001 -> words 0x0000,0x0001,0x0000,0x0000; last on 4th word; carry=0, zero=0, ovf=0.
- ADD: A=all-ones, B=1 -> all four words 0x0000; carry=1, zero=1, ovf=0.
- ADD: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> words 0x0000,0x0000,0x0000,0x8000; ovf=1, carry=0.
- SUB: A=B=0x1234_5678_9ABC_DEF0 -> all 0x0000; zero=1, carry=1.
- SUB: A=0, B=1 -> all 0xFFFF; carry=0.
- XOR with in_op changed to ADD on words 1-3 -> XOR result retained (op latched on word 0).
- Backpressure: out_ready pattern 1,0,0,1,0,1,1 -> each word held stable while stalled, no word lost or duplicated.
- in_ready=0 throughout output; in_valid held high during output is not consumed.
- Reset: assert reset_n=0 after the 2nd output word -> phase=3'b001 and out_valid=0 immediately. A new transaction (ADD 1+1) then yields 0x0002,0,0,0.
- N_WORDS=1 instance: ADD 0xFFFF+0x0001 -> single word 0x0000 with out_last=1, carry=1, zero=1. Phase goes 001 -> 100 directly.
